// File: rtl/sdram_rd_arbiter.sv
// rtl/sdram_rd_arbiter.sv - round-robin arbiter sharing one Avalon-MM SDRAM read master; optional feature macro VMX_ARB_TIMEOUT_EN
module sdram_rd_arbiter #(
    parameter int pNUM_REQ = 4,
    parameter int pADDR_W  = 24,
    parameter int pTIMEOUT = 256
) (
    input  logic                             iCLOCK,
    input  logic                             iRESET,
    input  logic [pNUM_REQ-1:0][pADDR_W-1:0] iREQ_ADDRESS,
    input  logic [pNUM_REQ-1:0]              iREQ_READ,
    output logic [pNUM_REQ-1:0]              oREQ_WAIT_REQUEST,
    output logic [15:0]                      oREQ_READ_DATA,
    output logic [pNUM_REQ-1:0]              oREQ_READ_DATA_VALID,
    output logic [pADDR_W-1:0]               oSDRAM_ADDRESS,
    output logic                             oSDRAM_READ,
    input  logic                             iSDRAM_WAIT_REQUEST,
    input  logic [15:0]                      iSDRAM_READ_DATA,
    input  logic                             iSDRAM_READ_DATA_VALID,
    output logic                             oTIMEOUT
);

    localparam int GW = (pNUM_REQ > 1) ? $clog2(pNUM_REQ) : 1;

    typedef enum logic [1:0] {
        sIDLE      = 2'd0,
        sISSUE     = 2'd1,
        sWAIT_DATA = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [GW-1:0] r_gnt;
    logic [GW-1:0] r_last;
    logic [GW-1:0] w_pick;
    logic          w_any_read;
    logic          w_accept;
    logic          w_timeout_hit;

    // First requester with read high, searching upward from the one after last served.
    function automatic logic [GW-1:0] rr_pick(input logic [pNUM_REQ-1:0] req,
                                              input logic [GW-1:0]       last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= pNUM_REQ; k++) begin
            idx = (int'(last) + k) % pNUM_REQ;
            if (!found && req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_any_read = |iREQ_READ;
    assign w_pick     = rr_pick(iREQ_READ, r_last);
    assign w_accept   = (r_state == sISSUE) && iREQ_READ[r_gnt] && !iSDRAM_WAIT_REQUEST;

`ifdef VMX_ARB_TIMEOUT_EN
    localparam int CW = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;

    logic [CW-1:0] r_wait_cnt;
    logic          r_timeout;

    assign w_timeout_hit = (r_state == sWAIT_DATA) && !iSDRAM_READ_DATA_VALID &&
                           (r_wait_cnt == CW'(pTIMEOUT - 1));
    assign oTIMEOUT      = r_timeout;

    // Cycles spent waiting for data; held at zero outside sWAIT_DATA so it starts clean on entry.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (r_state != sWAIT_DATA) begin
                r_wait_cnt <= '0;
            end else if (!iSDRAM_READ_DATA_VALID) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign oTIMEOUT      = 1'b0;
`endif

    // State, grant and last-served registers.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_state <= sIDLE;
            r_gnt   <= '0;
            r_last  <= GW'(pNUM_REQ - 1);
        end else begin
            r_state <= w_state_next;
            if ((r_state == sIDLE) && w_any_read) begin
                r_gnt <= w_pick;
            end
            if (w_accept) begin
                r_last <= r_gnt;
            end
        end
    end

    // Next state plus master/requester routing; everything defaults to the idle view.
    always_comb begin
        w_state_next         = r_state;
        oSDRAM_READ          = 1'b0;
        oSDRAM_ADDRESS       = iREQ_ADDRESS[r_gnt];
        oREQ_WAIT_REQUEST    = '1;
        oREQ_READ_DATA_VALID = '0;
        oREQ_READ_DATA       = iSDRAM_READ_DATA;
        case (r_state)
            sIDLE: begin
                if (w_any_read) begin
                    w_state_next = sISSUE;
                end
            end
            sISSUE: begin
                oSDRAM_READ              = iREQ_READ[r_gnt];
                oREQ_WAIT_REQUEST[r_gnt] = iSDRAM_WAIT_REQUEST;
                if (!iREQ_READ[r_gnt]) begin
                    // Granted requester withdrew its read: release without issuing.
                    w_state_next = sIDLE;
                end else if (!iSDRAM_WAIT_REQUEST) begin
                    w_state_next = sWAIT_DATA;
                end
            end
            sWAIT_DATA: begin
                if (iSDRAM_READ_DATA_VALID) begin
                    oREQ_READ_DATA_VALID[r_gnt] = 1'b1;
                    w_state_next                = sIDLE;
                end else if (w_timeout_hit) begin
                    // Lost read: hand the requester a zero word so it can move on.
                    oREQ_READ_DATA_VALID[r_gnt] = 1'b1;
                    oREQ_READ_DATA              = 16'h0000;
                    w_state_next                = sIDLE;
                end
            end
            default: begin
                w_state_next = sIDLE;
            end
        endcase
    end

endmodule
